ccp_job_sched: RTL and testbench
================================

Name: ccp_job_sched

Overview:
- Job-level sequencer in front of the ChaCha20-Poly1305 AEAD core.
- Accepts one job descriptor at a time: key, IV, constant and lengths.
- Issues the core start pulse, then moves AD beats (128 b) and PT blocks (512 b) from two valid/ready source streams into the core's request/enable handshake.
- Captures the final tag into a valid/ready output and guards the run with a watchdog.

Parameters:
- TIMEOUT, 65536: max cycles with no core activity (request or done) while in RUN before abort.
- CREDIT_MAX, 2: max outstanding core requests buffered per stream (AD and PT separately).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  async active-low reset
- i_job_valid  in  1  descriptor valid
- o_job_ready  out  1  descriptor accepted when high with valid
- i_job_key  in  256  key
- i_job_iv  in  64  IV
- i_job_const  in  32  nonce constant
- i_job_len_ad  in  64  AD length, bytes
- i_job_len_pt  in  32  PT length, bytes
- i_ad_valid / o_ad_ready  in/out  1  AD source handshake
- i_ad_data  in  128  AD beat
- i_pt_valid / o_pt_ready  in/out  1  PT source handshake
- i_pt_data  in  512  PT block
- o_core_start  out  1  one-cycle start pulse
- o_core_key / o_core_iv / o_core_const  out  256/64/32  latched descriptor, stable from start until next job accepted
- o_core_len_ad / o_core_len_pt  out  64/32  latched lengths
- i_core_rqst_ad / i_core_rqst_pt  in  1  core request pulses
- o_core_en_ad / o_core_en_pt  out  1  one-cycle data-enable pulses
- o_core_ad / o_core_pt  out  128/512  data, held until next enable
- i_core_done  in  1  core done pulse
- i_core_tag  in  128  tag, valid with done
- o_tag_valid / i_tag_ready  out/in  1  tag handshake
- o_tag  out  128  captured tag
- o_busy  out  1  state != IDLE
- o_err  out  1  one-cycle error pulse
- o_err_code  out  2  01 timeout, 10 spurious request, 11 early done; held until next o_err

Behaviour:
- Reset: i_rstn asynchronous, active-low; clock i_clk. All outputs 0, state IDLE, counters and credits 0. Reset mid-job discards the job with no tag and no error.
- States: IDLE -> START -> RUN -> TAG -> IDLE; timeout abort RUN -> IDLE.
- IDLE:
  - o_job_ready=1.
  - On valid&ready, latch the descriptor.
  - Load ad_left = ceil(len_ad/16) (64-bit arithmetic, len_ad=0 gives 0) and pt_left = ceil(len_pt/64) (32-bit).
  - Go to START.
- START: o_core_start=1 for exactly one cycle, then RUN. Latency from job accept to start is 1 cycle.
- RUN, credits:
  - Each i_core_rqst_ad increments ad_cred, saturating at CREDIT_MAX.
  - A request arriving while ad_left==0 is not counted and pulses o_err, code 10; the job continues.
  - PT credits follow the same rules with pt_cred, pt_left and i_core_rqst_pt.
- RUN, transfers:
  - o_ad_ready = (state==RUN) && ad_cred!=0 && ad_left!=0.
  - On an AD transfer, the next cycle has o_core_en_ad=1 and o_core_ad=data; ad_cred and ad_left each decrement.
  - A request and a transfer in the same cycle leave the credit unchanged.
  - PT works identically and independently; AD and PT may transfer in the same cycle.
- Watchdog: counter clears on any core request or done, and on entry to RUN. When it reaches TIMEOUT: o_err code 01, go IDLE, no tag.
- i_core_done in RUN:
  - Capture i_core_tag; go TAG.
  - If ad_left!=0 or pt_left!=0 at that moment, also pulse o_err code 11; the tag is still delivered.
- TAG:
  - o_tag_valid=1; o_tag stable until i_tag_ready.
  - On the handshake: o_tag_valid=0 next cycle, state IDLE.
  - A new job is accepted no earlier than the cycle after the tag handshake.
- i_core_done outside RUN is ignored.
- Source streams are never ready outside RUN, and o_core_en_* never pulses outside RUN or the cycle after a RUN transfer.

Test Plan:
- Basic job: len_ad=12, len_pt=114 -> ad_left=1, pt_left=2. Core issues 1 AD request and 2 PT requests; exactly 1 en_ad and 2 en_pt pulses each carry the source data; done with tag 0xA5..A5 -> o_tag_valid, o_tag=0xA5..A5; o_err stays 0.
- Zero lengths: len_ad=0, len_pt=0, core done after 40 cycles -> no ready on either stream, tag delivered, o_busy falls after the tag handshake.
- Credit saturation: 3 back-to-back AD requests with source stalled, len_ad=64 -> ad_cred=2. Then 2 transfers; a 4th request gives a 3rd transfer; total en_ad=3.
- Spurious/early: a PT request after pt_left=0 -> o_err code 10 for one cycle. Done with ad_left=1 -> code 11, tag still output.
- Timeout: TIMEOUT=16 with no core activity -> o_err code 01 at the 16th RUN cycle, state IDLE, o_tag_valid never set. A next job is accepted afterwards.
- Async reset mid-RUN, then a new job -> all outputs 0 immediately, no tag. The new job runs normally with fresh lengths.

Source files
------------

// File: rtl/ccp_job_sched.sv
// ccp_job_sched: job-level sequencer in front of the ChaCha20-Poly1305 AEAD core.
// Latches one descriptor, starts the core, feeds AD/PT beats against core credits and returns the tag.
module ccp_job_sched #(
  parameter int TIMEOUT    = 65536,
  parameter int CREDIT_MAX = 2
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_job_valid,
  output logic         o_job_ready,
  input  logic [255:0] i_job_key,
  input  logic [63:0]  i_job_iv,
  input  logic [31:0]  i_job_const,
  input  logic [63:0]  i_job_len_ad,
  input  logic [31:0]  i_job_len_pt,
  input  logic         i_ad_valid,
  output logic         o_ad_ready,
  input  logic [127:0] i_ad_data,
  input  logic         i_pt_valid,
  output logic         o_pt_ready,
  input  logic [511:0] i_pt_data,
  output logic         o_core_start,
  output logic [255:0] o_core_key,
  output logic [63:0]  o_core_iv,
  output logic [31:0]  o_core_const,
  output logic [63:0]  o_core_len_ad,
  output logic [31:0]  o_core_len_pt,
  input  logic         i_core_rqst_ad,
  input  logic         i_core_rqst_pt,
  output logic         o_core_en_ad,
  output logic         o_core_en_pt,
  output logic [127:0] o_core_ad,
  output logic [511:0] o_core_pt,
  input  logic         i_core_done,
  input  logic [127:0] i_core_tag,
  output logic         o_tag_valid,
  input  logic         i_tag_ready,
  output logic [127:0] o_tag,
  output logic         o_busy,
  output logic         o_err,
  output logic [1:0]   o_err_code
);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_TAG   = 2'd3;

  localparam logic [1:0] E_TIMEOUT  = 2'b01;
  localparam logic [1:0] E_SPURIOUS = 2'b10;
  localparam logic [1:0] E_EARLY    = 2'b11;

  logic [1:0]    r_state;
  logic          r_live;
  logic [63:0]   r_ad_left;
  logic [31:0]   r_pt_left;
  logic [CW-1:0] r_ad_cred, r_pt_cred;
  logic [WW-1:0] r_wdog;
  logic          r_en_ad, r_en_pt, r_err;
  logic [1:0]    r_err_code;
  logic [127:0]  r_core_ad, r_tag;
  logic [511:0]  r_core_pt;
  logic [255:0]  r_key;
  logic [63:0]   r_iv, r_len_ad;
  logic [31:0]   r_const, r_len_pt;

  logic          w_run, w_ad_xfer, w_pt_xfer, w_ad_rq_ok, w_pt_rq_ok;
  logic          w_spurious, w_early, w_activity, w_timeout, w_err;
  logic [1:0]    w_err_code;
  logic [63:0]   w_ad_blocks;
  logic [31:0]   w_pt_blocks;

  function automatic logic [CW-1:0] cred_next(input logic [CW-1:0] cred,
                                              input logic rq, input logic xfer);
    if (rq && !xfer) return (cred == CRED_FULL) ? cred : cred + CW'(1);
    if (xfer && !rq) return cred - CW'(1);
    return cred;
  endfunction

  assign w_run       = (r_state == S_RUN);
  // r_live keeps the descriptor port quiet while reset is asserted.
  assign o_job_ready = r_live && (r_state == S_IDLE);
  assign o_ad_ready  = w_run && (r_ad_cred != '0) && (r_ad_left != '0);
  assign o_pt_ready  = w_run && (r_pt_cred != '0) && (r_pt_left != '0);
  assign w_ad_xfer   = i_ad_valid && o_ad_ready;
  assign w_pt_xfer   = i_pt_valid && o_pt_ready;
  assign w_ad_rq_ok  = w_run && i_core_rqst_ad && (r_ad_left != '0);
  assign w_pt_rq_ok  = w_run && i_core_rqst_pt && (r_pt_left != '0);
  assign w_spurious  = w_run && ((i_core_rqst_ad && (r_ad_left == '0)) ||
                                 (i_core_rqst_pt && (r_pt_left == '0)));
  assign w_early     = w_run && i_core_done && ((r_ad_left != '0) || (r_pt_left != '0));
  assign w_activity  = i_core_rqst_ad || i_core_rqst_pt || i_core_done;
  assign w_timeout   = w_run && !w_activity && (r_wdog == WDOG_LAST);
  assign w_ad_blocks = (i_job_len_ad >> 4) + 64'(|i_job_len_ad[3:0]);
  assign w_pt_blocks = (i_job_len_pt >> 6) + 32'(|i_job_len_pt[5:0]);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    w_err      = 1'b0;
    w_err_code = r_err_code;
    if (w_early) begin
      w_err      = 1'b1;
      w_err_code = E_EARLY;
    end else if (w_spurious) begin
      w_err      = 1'b1;
      w_err_code = E_SPURIOUS;
    end else if (w_timeout) begin
      w_err      = 1'b1;
      w_err_code = E_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= S_IDLE;
      r_live     <= 1'b0;
      r_ad_left  <= '0;
      r_pt_left  <= '0;
      r_ad_cred  <= '0;
      r_pt_cred  <= '0;
      r_wdog     <= '0;
      r_en_ad    <= 1'b0;
      r_en_pt    <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= '0;
      r_core_ad  <= '0;
      r_core_pt  <= '0;
      r_tag      <= '0;
      r_key      <= '0;
      r_iv       <= '0;
      r_const    <= '0;
      r_len_ad   <= '0;
      r_len_pt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_live     <= 1'b1;
      r_en_ad    <= w_ad_xfer;
      r_en_pt    <= w_pt_xfer;
      r_err      <= w_err;
      r_err_code <= w_err_code;
      if (w_ad_xfer) r_core_ad <= i_ad_data;
      if (w_pt_xfer) r_core_pt <= i_pt_data;
      case (r_state)
        S_IDLE: begin
          if (i_job_valid && o_job_ready) begin
            r_key     <= i_job_key;
            r_iv      <= i_job_iv;
            r_const   <= i_job_const;
            r_len_ad  <= i_job_len_ad;
            r_len_pt  <= i_job_len_pt;
            r_ad_left <= w_ad_blocks;
            r_pt_left <= w_pt_blocks;
            r_ad_cred <= '0;
            r_pt_cred <= '0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_wdog  <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_ad_cred <= cred_next(r_ad_cred, w_ad_rq_ok, w_ad_xfer);
          r_pt_cred <= cred_next(r_pt_cred, w_pt_rq_ok, w_pt_xfer);
          if (w_ad_xfer) r_ad_left <= r_ad_left - 64'd1;
          if (w_pt_xfer) r_pt_left <= r_pt_left - 32'd1;
          r_wdog <= w_activity ? '0 : r_wdog + WW'(1);
          if (i_core_done) begin
            r_tag   <= i_core_tag;
            r_state <= S_TAG;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end
        end
        S_TAG: begin
          if (i_tag_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_core_start  = (r_state == S_START);
  assign o_tag_valid   = (r_state == S_TAG);
  assign o_busy        = (r_state != S_IDLE);
  assign o_core_key    = r_key;
  assign o_core_iv     = r_iv;
  assign o_core_const  = r_const;
  assign o_core_len_ad = r_len_ad;
  assign o_core_len_pt = r_len_pt;
  assign o_core_en_ad  = r_en_ad;
  assign o_core_en_pt  = r_en_pt;
  assign o_core_ad     = r_core_ad;
  assign o_core_pt     = r_core_pt;
  assign o_tag         = r_tag;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;
endmodule

// File: tb/tb_ccp_job_sched.sv
// Bench for ccp_job_sched: scoreboard of expected core beats and error codes, one task per scenario.
// A second instance with TIMEOUT=16 exercises the watchdog; it shares all inputs with the main one.
module tb_ccp_job_sched;
  logic         i_clk = 1'b0;
  logic         i_rstn;
  logic         i_job_valid;
  logic [255:0] i_job_key;
  logic [63:0]  i_job_iv;
  logic [31:0]  i_job_const;
  logic [63:0]  i_job_len_ad;
  logic [31:0]  i_job_len_pt;
  logic         i_ad_valid, i_pt_valid;
  logic [127:0] i_ad_data;
  logic [511:0] i_pt_data;
  logic         i_core_rqst_ad, i_core_rqst_pt, i_core_done, i_tag_ready;
  logic [127:0] i_core_tag;

  logic         o_job_ready, o_ad_ready, o_pt_ready, o_core_start;
  logic [255:0] o_core_key;
  logic [63:0]  o_core_iv, o_core_len_ad;
  logic [31:0]  o_core_const, o_core_len_pt;
  logic         o_core_en_ad, o_core_en_pt, o_tag_valid, o_busy, o_err;
  logic [127:0] o_core_ad, o_tag;
  logic [511:0] o_core_pt;
  logic [1:0]   o_err_code;

  logic         to_job_ready, to_ad_ready, to_pt_ready, to_core_start;
  logic [255:0] to_core_key;
  logic [63:0]  to_core_iv, to_core_len_ad;
  logic [31:0]  to_core_const, to_core_len_pt;
  logic         to_core_en_ad, to_core_en_pt, to_tag_valid, to_busy, to_err;
  logic [127:0] to_core_ad, to_tag;
  logic [511:0] to_core_pt;
  logic [1:0]   to_err_code;

  always #5 i_clk = ~i_clk;

  ccp_job_sched #(.TIMEOUT(64), .CREDIT_MAX(2)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_job_valid(i_job_valid), .o_job_ready(o_job_ready),
    .i_job_key(i_job_key), .i_job_iv(i_job_iv), .i_job_const(i_job_const),
    .i_job_len_ad(i_job_len_ad), .i_job_len_pt(i_job_len_pt),
    .i_ad_valid(i_ad_valid), .o_ad_ready(o_ad_ready), .i_ad_data(i_ad_data),
    .i_pt_valid(i_pt_valid), .o_pt_ready(o_pt_ready), .i_pt_data(i_pt_data),
    .o_core_start(o_core_start), .o_core_key(o_core_key), .o_core_iv(o_core_iv),
    .o_core_const(o_core_const), .o_core_len_ad(o_core_len_ad), .o_core_len_pt(o_core_len_pt),
    .i_core_rqst_ad(i_core_rqst_ad), .i_core_rqst_pt(i_core_rqst_pt),
    .o_core_en_ad(o_core_en_ad), .o_core_en_pt(o_core_en_pt),
    .o_core_ad(o_core_ad), .o_core_pt(o_core_pt),
    .i_core_done(i_core_done), .i_core_tag(i_core_tag),
    .o_tag_valid(o_tag_valid), .i_tag_ready(i_tag_ready), .o_tag(o_tag),
    .o_busy(o_busy), .o_err(o_err), .o_err_code(o_err_code)
  );

  ccp_job_sched #(.TIMEOUT(16), .CREDIT_MAX(2)) dut_to (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_job_valid(i_job_valid), .o_job_ready(to_job_ready),
    .i_job_key(i_job_key), .i_job_iv(i_job_iv), .i_job_const(i_job_const),
    .i_job_len_ad(i_job_len_ad), .i_job_len_pt(i_job_len_pt),
    .i_ad_valid(i_ad_valid), .o_ad_ready(to_ad_ready), .i_ad_data(i_ad_data),
    .i_pt_valid(i_pt_valid), .o_pt_ready(to_pt_ready), .i_pt_data(i_pt_data),
    .o_core_start(to_core_start), .o_core_key(to_core_key), .o_core_iv(to_core_iv),
    .o_core_const(to_core_const), .o_core_len_ad(to_core_len_ad), .o_core_len_pt(to_core_len_pt),
    .i_core_rqst_ad(i_core_rqst_ad), .i_core_rqst_pt(i_core_rqst_pt),
    .o_core_en_ad(to_core_en_ad), .o_core_en_pt(to_core_en_pt),
    .o_core_ad(to_core_ad), .o_core_pt(to_core_pt),
    .i_core_done(i_core_done), .i_core_tag(i_core_tag),
    .o_tag_valid(to_tag_valid), .i_tag_ready(i_tag_ready), .o_tag(to_tag),
    .o_busy(to_busy), .o_err(to_err), .o_err_code(to_err_code)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_en_ad, n_en_pt, n_err_seen;
  logic [127:0] exp_ad_q[$];
  logic [511:0] exp_pt_q[$];
  logic [1:0]   exp_err_q[$];
  logic [255:0] last_key;

  // One clock: record source handshakes, advance, then score core beats and error pulses.
  task automatic tick();
    logic ad_fire, pt_fire;
    logic [127:0] ea;
    logic [511:0] ep;
    logic [1:0]   ee;
    ad_fire = i_ad_valid && o_ad_ready;
    pt_fire = i_pt_valid && o_pt_ready;
    if (ad_fire) exp_ad_q.push_back(i_ad_data);
    if (pt_fire) exp_pt_q.push_back(i_pt_data);
    @(posedge i_clk);
    #1;
    if (ad_fire) i_ad_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    if (pt_fire) for (int i = 0; i < 16; i++) i_pt_data[i*32 +: 32] = $urandom();
    if (ad_fire) begin
      n_checks++;
      if (o_core_en_ad !== 1'b1) begin
        n_errors++;
        $display("FAIL en_ad_after_xfer: en_ad=%b required 1", o_core_en_ad);
      end
    end
    if (pt_fire) begin
      n_checks++;
      if (o_core_en_pt !== 1'b1) begin
        n_errors++;
        $display("FAIL en_pt_after_xfer: en_pt=%b required 1", o_core_en_pt);
      end
    end
    if (o_core_en_ad === 1'b1) begin
      n_en_ad++;
      n_checks++;
      if (exp_ad_q.size() == 0) begin
        n_errors++;
        $display("FAIL en_ad_unexpected: en_ad=1 with no AD transfer pending");
      end else begin
        ea = exp_ad_q.pop_front();
        if (o_core_ad !== ea) begin
          n_errors++;
          $display("FAIL core_ad_data: got %h required %h", o_core_ad, ea);
        end
      end
    end
    if (o_core_en_pt === 1'b1) begin
      n_en_pt++;
      n_checks++;
      if (exp_pt_q.size() == 0) begin
        n_errors++;
        $display("FAIL en_pt_unexpected: en_pt=1 with no PT transfer pending");
      end else begin
        ep = exp_pt_q.pop_front();
        if (o_core_pt !== ep) begin
          n_errors++;
          $display("FAIL core_pt_data: got %h required %h", o_core_pt[63:0], ep[63:0]);
        end
      end
    end
    if (o_err === 1'b1) begin
      n_err_seen++;
      n_checks++;
      if (exp_err_q.size() == 0) begin
        n_errors++;
        $display("FAIL err_unexpected: o_err=1 code=%b required no error", o_err_code);
      end else begin
        ee = exp_err_q.pop_front();
        if (o_err_code !== ee) begin
          n_errors++;
          $display("FAIL err_code: got %b required %b", o_err_code, ee);
        end
      end
    end
  endtask

  task automatic clear_inputs();
    i_job_valid = 0; i_job_key = '0; i_job_iv = '0; i_job_const = '0;
    i_job_len_ad = '0; i_job_len_pt = '0;
    i_ad_valid = 0; i_pt_valid = 0; i_ad_data = 128'h1111; i_pt_data = 512'h2222;
    i_core_rqst_ad = 0; i_core_rqst_pt = 0; i_core_done = 0; i_core_tag = '0; i_tag_ready = 0;
  endtask

  task automatic clear_board();
    exp_ad_q.delete(); exp_pt_q.delete(); exp_err_q.delete();
    n_en_ad = 0; n_en_pt = 0; n_err_seen = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_rstn = 0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1;
    clear_board();
    tick();
  endtask

  // Present a descriptor to the main instance and hold it until accepted (bounded).
  task automatic send_job(input logic [63:0] len_ad, input logic [31:0] len_pt);
    bit accepted;
    accepted = 0;
    last_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    i_job_key = last_key; i_job_iv = {$urandom(), $urandom()}; i_job_const = $urandom();
    i_job_len_ad = len_ad; i_job_len_pt = len_pt; i_job_valid = 1;
    for (int i = 0; i < 10 && !accepted; i++) begin
      accepted = o_job_ready;
      tick();
    end
    i_job_valid = 0;
    n_checks++;
    if (!accepted) begin
      n_errors++;
      $display("FAIL job_accept: job_ready=0 required 1 within 10 cycles");
    end
  endtask

  task automatic wait_tag(output bit ok);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (o_tag_valid === 1'b1) ok = 1;
      else tick();
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    clear_board();
    i_rstn = 0;
    #3;
    n_checks++;
    if ({o_job_ready, o_busy, o_core_start, o_tag_valid, o_err, o_ad_ready, o_pt_ready} !== 7'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: ready/busy/start/tag/err/adr/ptr=%b required 0000000",
               {o_job_ready, o_busy, o_core_start, o_tag_valid, o_err, o_ad_ready, o_pt_ready});
    end
    n_checks++;
    if (o_err_code !== 2'b00 || o_core_key !== '0 || o_tag !== '0) begin
      n_errors++;
      $display("FAIL reset_data: err_code=%b key_nz=%b tag_nz=%b required 00 0 0",
               o_err_code, |o_core_key, |o_tag);
    end
    @(posedge i_clk);
    #1;
    i_rstn = 1;
    tick();
    n_checks++;
    if (o_job_ready !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: job_ready=%b busy=%b required 1 0", o_job_ready, o_busy);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    i_ad_valid = 1; i_pt_valid = 1;
    send_job(64'd12, 32'd114);
    n_checks++;
    if (o_core_start !== 1'b1 || o_core_key !== last_key || o_core_len_ad !== 64'd12 ||
        o_core_len_pt !== 32'd114) begin
      n_errors++;
      $display("FAIL basic_start: start=%b len_ad=%0d len_pt=%0d key_ok=%b required 1 12 114 1",
               o_core_start, o_core_len_ad, o_core_len_pt, o_core_key === last_key);
    end
    tick();
    n_checks++;
    if (o_core_start !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_start_pulse: start=%b required 0", o_core_start);
    end
    i_core_rqst_ad = 1; i_core_rqst_pt = 1;
    tick();
    i_core_rqst_ad = 0;
    tick();
    i_core_rqst_pt = 0;
    repeat (6) tick();
    n_checks++;
    if (n_en_ad != 1 || n_en_pt != 2) begin
      n_errors++;
      $display("FAIL basic_en_count: en_ad=%0d en_pt=%0d required 1 2", n_en_ad, n_en_pt);
    end
    i_core_done = 1; i_core_tag = {16{8'hA5}};
    tick();
    i_core_done = 0; i_core_tag = '0;
    wait_tag(ok);
    n_checks++;
    if (!ok || o_tag !== {16{8'hA5}}) begin
      n_errors++;
      $display("FAIL basic_tag: tag_valid=%b tag=%h required 1 %h", ok, o_tag, {16{8'hA5}});
    end
    i_tag_ready = 1;
    tick();
    i_tag_ready = 0;
    n_checks++;
    if (o_tag_valid !== 1'b0 || o_busy !== 1'b0 || n_err_seen != 0) begin
      n_errors++;
      $display("FAIL basic_end: tag_valid=%b busy=%b errs=%0d required 0 0 0",
               o_tag_valid, o_busy, n_err_seen);
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    int n_ready;
    n_ready = 0;
    do_reset();
    i_ad_valid = 1; i_pt_valid = 1;
    send_job(64'd0, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (o_ad_ready || o_pt_ready) n_ready++;
      tick();
    end
    n_checks++;
    if (n_ready != 0 || n_en_ad != 0 || n_en_pt != 0) begin
      n_errors++;
      $display("FAIL zero_no_ready: ready_cycles=%0d en_ad=%0d en_pt=%0d required 0 0 0",
               n_ready, n_en_ad, n_en_pt);
    end
    i_core_done = 1; i_core_tag = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    tick();
    i_core_done = 0;
    wait_tag(ok);
    n_checks++;
    if (!ok || o_tag !== 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL zero_tag: tag_valid=%b busy=%b tag=%h required 1 1 0123..3210", ok, o_busy, o_tag);
    end
    i_tag_ready = 1;
    tick();
    i_tag_ready = 0;
    n_checks++;
    if (o_busy !== 1'b0 || n_err_seen != 0) begin
      n_errors++;
      $display("FAIL zero_busy_fall: busy=%b errs=%0d required 0 0", o_busy, n_err_seen);
    end
  endtask

  task automatic test_credit_sat();
    bit ok;
    do_reset();
    send_job(64'd64, 32'd0);
    tick();
    i_core_rqst_ad = 1;
    repeat (3) tick();
    i_core_rqst_ad = 0;
    repeat (2) tick();
    i_ad_valid = 1;
    repeat (5) tick();
    n_checks++;
    if (n_en_ad != 2) begin
      n_errors++;
      $display("FAIL credit_sat: en_ad=%0d required 2", n_en_ad);
    end
    i_core_rqst_ad = 1;
    tick();
    i_core_rqst_ad = 0;
    repeat (4) tick();
    n_checks++;
    if (n_en_ad != 3) begin
      n_errors++;
      $display("FAIL credit_refill: en_ad=%0d required 3", n_en_ad);
    end
    exp_err_q.push_back(2'b11);
    i_core_done = 1; i_core_tag = {4{32'hC0DE_0003}};
    tick();
    i_core_done = 0;
    wait_tag(ok);
    i_tag_ready = 1;
    tick();
    i_tag_ready = 0;
    n_checks++;
    if (!ok || n_err_seen != 1 || exp_err_q.size() != 0 || o_err_code !== 2'b11) begin
      n_errors++;
      $display("FAIL credit_early_done: tag=%b errs=%0d code=%b required 1 1 11",
               ok, n_err_seen, o_err_code);
    end
  endtask

  task automatic test_spurious_early();
    bit ok;
    do_reset();
    i_pt_valid = 1;
    send_job(64'd16, 32'd64);
    tick();
    i_core_rqst_pt = 1;
    tick();
    i_core_rqst_pt = 0;
    repeat (3) tick();
    exp_err_q.push_back(2'b10);
    i_core_rqst_pt = 1;
    tick();
    i_core_rqst_pt = 0;
    n_checks++;
    if (o_err !== 1'b1 || o_err_code !== 2'b10) begin
      n_errors++;
      $display("FAIL spurious_err: err=%b code=%b required 1 10", o_err, o_err_code);
    end
    tick();
    n_checks++;
    if (o_err !== 1'b0 || o_err_code !== 2'b10 || o_busy !== 1'b1 || n_en_pt != 1) begin
      n_errors++;
      $display("FAIL spurious_pulse: err=%b code=%b busy=%b en_pt=%0d required 0 10 1 1",
               o_err, o_err_code, o_busy, n_en_pt);
    end
    exp_err_q.push_back(2'b11);
    i_core_done = 1; i_core_tag = {4{32'hBEEF_0011}};
    tick();
    i_core_done = 0;
    wait_tag(ok);
    n_checks++;
    if (!ok || o_tag !== {4{32'hBEEF_0011}} || exp_err_q.size() != 0) begin
      n_errors++;
      $display("FAIL early_tag: tag_valid=%b tag=%h pending_errs=%0d required 1 BEEF0011x4 0",
               ok, o_tag, exp_err_q.size());
    end
    i_tag_ready = 1;
    tick();
    i_tag_ready = 0;
  endtask

  task automatic test_timeout();
    int  cycles;
    bit  seen_err, seen_tag;
    seen_err = 0; seen_tag = 0; cycles = 0;
    do_reset();
    send_job(64'd16, 32'd64);
    n_checks++;
    if (to_core_start !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_start: start=%b required 1", to_core_start);
    end
    for (int i = 0; i < 40 && !seen_err; i++) begin
      tick();
      cycles++;
      if (to_tag_valid === 1'b1) seen_tag = 1;
      if (to_err === 1'b1) seen_err = 1;
    end
    n_checks++;
    if (!seen_err || cycles != 17 || to_err_code !== 2'b01 || to_busy !== 1'b0 || seen_tag) begin
      n_errors++;
      $display("FAIL timeout_abort: err=%b cycles=%0d code=%b busy=%b tag=%b required 1 17 01 0 0",
               seen_err, cycles, to_err_code, to_busy, seen_tag);
    end
    i_job_valid = 1; i_job_len_ad = 64'd100; i_job_len_pt = 32'd7;
    n_checks++;
    if (to_job_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_next_ready: job_ready=%b required 1", to_job_ready);
    end
    tick();
    i_job_valid = 0;
    n_checks++;
    if (to_core_start !== 1'b1 || to_core_len_ad !== 64'd100 || to_core_len_pt !== 32'd7) begin
      n_errors++;
      $display("FAIL timeout_next_job: start=%b len_ad=%0d len_pt=%0d required 1 100 7",
               to_core_start, to_core_len_ad, to_core_len_pt);
    end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    do_reset();
    i_ad_valid = 1; i_pt_valid = 1;
    send_job(64'd32, 32'd128);
    tick();
    i_core_rqst_ad = 1;
    tick();
    i_core_rqst_ad = 0;
    repeat (3) tick();
    n_checks++;
    if (n_en_ad != 1 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL midrun_pre: en_ad=%0d busy=%b required 1 1", n_en_ad, o_busy);
    end
    i_rstn = 0;
    #2;
    n_checks++;
    if ({o_busy, o_tag_valid, o_ad_ready, o_core_en_ad, o_err} !== 5'b0 ||
        o_core_ad !== '0 || o_core_key !== '0 || o_core_len_ad !== '0) begin
      n_errors++;
      $display("FAIL midrun_reset: busy/tag/adr/en/err=%b ad_nz=%b key_nz=%b len_ad=%0d required 00000 0 0 0",
               {o_busy, o_tag_valid, o_ad_ready, o_core_en_ad, o_err}, |o_core_ad, |o_core_key, o_core_len_ad);
    end
    @(posedge i_clk);
    #1;
    i_rstn = 1;
    clear_board();
    tick();
    send_job(64'd16, 32'd64);
    tick();
    i_core_rqst_ad = 1; i_core_rqst_pt = 1;
    tick();
    i_core_rqst_ad = 0; i_core_rqst_pt = 0;
    repeat (4) tick();
    i_core_done = 1; i_core_tag = {8{16'h5A5A}};
    tick();
    i_core_done = 0;
    wait_tag(ok);
    n_checks++;
    if (!ok || o_tag !== {8{16'h5A5A}} || n_en_ad != 1 || n_en_pt != 1 || n_err_seen != 0) begin
      n_errors++;
      $display("FAIL midrun_new_job: tag_valid=%b en_ad=%0d en_pt=%0d errs=%0d required 1 1 1 0",
               ok, n_en_ad, n_en_pt, n_err_seen);
    end
    i_tag_ready = 1;
    tick();
    i_tag_ready = 0;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midrun_done: busy=%b required 0", o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_credit_sat();
    test_spurious_early();
    test_timeout();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit reached");
  end
endmodule
